// File: rtl/demod_pkg.sv
// Shared definitions for the demodulation path: FSM states and default datapath widths.
package demod_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } demod_state_t;

  localparam int unsigned DEF_NX        = 16;
  localparam int unsigned DEF_NACC      = 24;
  localparam int unsigned DEF_NOUT      = 16;
  localparam int unsigned DEF_SYM_LEN_W = 8;

  // Accumulator must hold a full symbol of worst-case products without wrapping.
  localparam bit DEF_ACC_FITS = (DEF_NACC >= DEF_NX + DEF_SYM_LEN_W);

endpackage

// File: rtl/demod_sat_shift.sv
// Arithmetic right shift followed by signed saturation from NIN to NOUT bits.
module demod_sat_shift #(
  parameter int unsigned NIN   = 24,
  parameter int unsigned NOUT  = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic [NIN-1:0]  din,
  output logic [NOUT-1:0] dout_c,
  output logic            sat_c
);

  localparam logic signed [NIN-1:0] MAXV = NIN'({1'b0, {(NOUT-1){1'b1}}});
  localparam logic signed [NIN-1:0] MINV = ~MAXV;

  logic signed [NIN-1:0] shifted;

  assign shifted = $signed(din) >>> SHIFT;

  // Clip to the NOUT-bit signed range and flag any clipping.
  always_comb begin
    dout_c = shifted[NOUT-1:0];
    sat_c  = 1'b0;
    if (shifted > MAXV) begin
      dout_c = MAXV[NOUT-1:0];
      sat_c  = 1'b1;
    end else if (shifted < MINV) begin
      dout_c = MINV[NOUT-1:0];
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/demod_integrate_dump.sv
// Integrate-and-dump: sums signed products over a programmable symbol length and
// emits a scaled, saturated soft value plus hard decision at each symbol boundary.
module demod_integrate_dump
  import demod_pkg::*;
#(
  parameter int unsigned NX        = DEF_NX,
  parameter int unsigned NACC      = DEF_NACC,
  parameter int unsigned NOUT      = DEF_NOUT,
  parameter int unsigned SYM_LEN_W = DEF_SYM_LEN_W,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SYM_LEN_W-1:0] sym_len,
  input  logic                 in_valid,
  input  logic [NX-1:0]        in_data,
  output logic                 busy,
  output logic                 out_valid,
  output logic [NOUT-1:0]      out_data,
  output logic                 out_bit,
  output logic                 out_sat
);

  if (NACC < NX + SYM_LEN_W) begin : g_width_check
    $error("demod_integrate_dump: NACC too narrow for NX + SYM_LEN_W");
  end

  demod_state_t state, state_d;

  logic signed [NACC-1:0] acc, acc_d;
  logic [SYM_LEN_W-1:0]   cnt, cnt_d;
  logic [SYM_LEN_W-1:0]   len_q, len_d;

  logic signed [NACC-1:0] in_ext;
  logic signed [NACC-1:0] base_acc;
  logic signed [NACC-1:0] sum_c;
  logic [SYM_LEN_W-1:0]   base_cnt;
  logic [SYM_LEN_W-1:0]   eff_len;
  logic [SYM_LEN_W-1:0]   len_new;
  logic                   dump_c;

  logic [NOUT-1:0]        sat_data_c;
  logic                   sat_flag_c;

  assign in_ext = NACC'($signed(in_data));

  // A start abandons any partial symbol, so the sample arriving with it sees a cleared context.
  always_comb begin
    len_new  = (sym_len == '0) ? SYM_LEN_W'(1) : sym_len;
    base_acc = start ? '0 : acc;
    base_cnt = start ? '0 : cnt;
    eff_len  = start ? len_new : len_q;
    sum_c    = base_acc + in_ext;
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    len_d   = len_q;
    dump_c  = 1'b0;
    if (start) begin
      state_d = ST_ACCUM;
      len_d   = len_new;
      acc_d   = '0;
      cnt_d   = '0;
    end
    if ((start || (state == ST_ACCUM)) && in_valid) begin
      if (base_cnt == eff_len - SYM_LEN_W'(1)) begin
        dump_c = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = base_cnt + SYM_LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= SYM_LEN_W'(1);
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      len_q <= len_d;
    end
  end

  demod_sat_shift #(
    .NIN   (NACC),
    .NOUT  (NOUT),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .din    (sum_c),
    .dout_c (sat_data_c),
    .sat_c  (sat_flag_c)
  );

  // Dump results hold until the next dump; out_valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bit   <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      busy      <= (state_d == ST_ACCUM);
      out_valid <= dump_c;
      if (dump_c) begin
        out_data <= sat_data_c;
        out_bit  <= ~sum_c[NACC-1];
        out_sat  <= sat_flag_c;
      end
    end
  end

endmodule

// File: tb/tb_demod_integrate_dump.sv
// Directed bench for demod_integrate_dump; a second instance with SHIFT=2 covers scaling.
module tb_demod_integrate_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sym_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;

  logic        busy, out_valid, out_bit, out_sat;
  logic [15:0] out_data;
  logic        s2_busy, s2_out_valid, s2_out_bit, s2_out_sat;
  logic [15:0] s2_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demod_integrate_dump #(.SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_len(sym_len),
    .in_valid(in_valid), .in_data(in_data), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_bit(out_bit), .out_sat(out_sat)
  );

  demod_integrate_dump #(.SHIFT(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_len(sym_len),
    .in_valid(in_valid), .in_data(in_data), .busy(s2_busy),
    .out_valid(s2_out_valid), .out_data(s2_out_data), .out_bit(s2_out_bit), .out_sat(s2_out_sat)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dump(input string tag, input int d, input logic b, input logic s);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_data"}, $signed(out_data), d);
    chk({tag, "_bit"}, 32'(out_bit), 32'(b));
    chk({tag, "_sat"}, 32'(out_sat), 32'(s));
  endtask

  // One clock of stimulus; returns 1 time unit after the edge so registered outputs are settled.
  task automatic drive(input logic s, input logic [7:0] l, input logic v, input logic [15:0] d);
    start = s; sym_len = l; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", $signed(out_data), 0);
    chk("rst_bit", 32'(out_bit), 0);
    chk("rst_sat", 32'(out_sat), 0);
    rst_n = 1'b1;

    // Samples while idle are ignored
    drive(0, 4, 1, 16'd50);
    chk("idle_valid0", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd60);
    chk("idle_valid1", 32'(out_valid), 0);
    chk("idle_busy", 32'(busy), 0);

    // Basic dump
    drive(1, 4, 0, 0);
    chk("busy_after_start", 32'(busy), 1);
    drive(0, 4, 1, 16'd100);
    drive(0, 4, 1, 16'd200);
    drive(0, 4, 1, -16'sd50);
    chk("basic_early", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd10);
    chk_dump("basic", 260, 1'b1, 1'b0);
    drive(0, 4, 0, 0);
    chk("basic_pulse", 32'(out_valid), 0);
    chk("basic_hold", $signed(out_data), 260);

    // Positive and negative saturation; SHIFT=2 instance fits without clipping
    repeat (4) drive(0, 4, 1, 16'd32767);
    chk_dump("satpos", 32767, 1'b1, 1'b1);
    chk("s2pos_valid", 32'(s2_out_valid), 1);
    chk("s2pos_data", $signed(s2_out_data), 32767);
    chk("s2pos_sat", 32'(s2_out_sat), 0);
    repeat (4) drive(0, 4, 1, 16'h8000);
    chk_dump("satneg", -32768, 1'b0, 1'b1);
    chk("s2neg_data", $signed(s2_out_data), -32768);
    chk("s2neg_sat", 32'(s2_out_sat), 0);

    // Gapped input gives the same result
    drive(0, 4, 1, 16'd100);
    drive(0, 4, 0, 0);
    chk("gap_novalid", 32'(out_valid), 0);
    drive(0, 4, 0, 0);
    drive(0, 4, 1, 16'd200);
    drive(0, 4, 0, 0);
    drive(0, 4, 1, -16'sd50);
    drive(0, 4, 0, 0);
    drive(0, 4, 0, 0);
    drive(0, 4, 0, 0);
    chk("gap_early", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd10);
    chk_dump("gap", 260, 1'b1, 1'b0);

    // Twelve back-to-back samples: dumps of 10, 26, 42 every fourth cycle
    for (int k = 0; k < 12; k++) begin
      drive(0, 4, 1, 16'(k + 1));
      chk($sformatf("b2b_valid%0d", k), 32'(out_valid), 32'((k % 4) == 3));
      if ((k % 4) == 3)
        chk($sformatf("b2b_data%0d", k), $signed(out_data), 10 + 16 * (k / 4));
    end

    // sym_len=0 behaves as 1: every sample dumps, including the one arriving with start
    drive(1, 0, 1, -16'sd5);
    chk_dump("len1_a", -5, 1'b0, 1'b0);
    drive(0, 0, 1, 16'd7);
    chk_dump("len1_b", 7, 1'b1, 1'b0);
    drive(0, 0, 1, -16'sd300);
    chk_dump("len1_c", -300, 1'b0, 1'b0);
    drive(0, 0, 1, 16'd0);
    chk_dump("len1_d", 0, 1'b1, 1'b0);
    drive(0, 0, 0, 0);
    chk("len1_stop", 32'(out_valid), 0);

    // Realign discards the partial symbol of 5+7
    drive(1, 4, 0, 0);
    drive(0, 4, 1, 16'd5);
    drive(0, 4, 1, 16'd7);
    drive(1, 4, 1, 16'd1);
    chk("realign_v0", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd1);
    chk("realign_v1", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd1);
    chk("realign_v2", 32'(out_valid), 0);
    drive(0, 4, 1, 16'd1);
    chk_dump("realign", 4, 1'b1, 1'b0);

    // Start on a final sample wins; sym_len changes without start are ignored
    drive(0, 2, 1, 16'd10);
    drive(0, 2, 1, 16'd20);
    chk("prio_lenchg", 32'(out_valid), 0);
    drive(0, 2, 1, 16'd30);
    drive(1, 4, 1, 16'd40);
    chk("prio_nodump", 32'(out_valid), 0);
    chk("prio_hold", $signed(out_data), 4);
    drive(0, 2, 1, 16'd1);
    drive(0, 2, 1, 16'd2);
    chk("prio_early", 32'(out_valid), 0);
    drive(0, 2, 1, 16'd3);
    chk_dump("prio", 46, 1'b1, 1'b0);

    // Asynchronous reset mid-symbol
    drive(0, 4, 1, 16'd3);
    drive(0, 4, 1, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", $signed(out_data), 0);
    chk("arst_bit", 32'(out_bit), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 4, 1, 16'd9);
    drive(0, 4, 1, 16'd9);
    chk("arst_idle_valid", 32'(out_valid), 0);
    chk("arst_idle_busy", 32'(busy), 0);
    drive(1, 4, 0, 0);
    chk("arst_restart_busy", 32'(busy), 1);
    drive(0, 4, 1, 16'd1);
    drive(0, 4, 1, 16'd2);
    drive(0, 4, 1, 16'd3);
    drive(0, 4, 1, 16'd4);
    chk_dump("arst_fresh", 10, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demod_integrate_dump.md
# demod_integrate_dump

Integrate-and-dump stage that sits directly downstream of the signed 8x8 product multiplier in the demodulation path. It accumulates a stream of signed mixer products over one symbol period, with a programmable symbol length. At each symbol boundary it dumps a scaled, saturated soft value and a hard bit decision, then restarts with no dead cycle.

## Interface
- NX, 16: signed input (product) width
- NACC, 24: accumulator width; must satisfy NACC >= NX + SYM_LEN_W (no internal wrap possible)
- NOUT, 16: signed soft-output width
- SYM_LEN_W, 8: width of the symbol-length port
- SHIFT, 0: arithmetic right shift applied to the dumped sum before saturation
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  1-cycle pulse; aligns and (re)starts symbol integration
- sym_len  in  SYM_LEN_W  samples per symbol, sampled on start; 0 is treated as 1
- in_valid  in  1  in_data is valid this cycle
- in_data  in  NX  signed two's-complement product sample
- busy  out  1  1 while in ACCUM
- out_valid  out  1  1-cycle pulse; out_data/out_bit/out_sat are valid
- out_data  out  NOUT  signed soft value: sat(sum >>> SHIFT)
- out_bit  out  1  hard decision: 1 if sum >= 0, else 0
- out_sat  out  1  1 if out_data was clipped

## Operation
- States: IDLE and ACCUM. Reset puts the block in IDLE with acc=0, cnt=0, len_q=1 and all outputs at 0.
- IDLE:
  - in_valid is ignored.
  - start: latch len_q = (sym_len==0 ? 1 : sym_len), clear acc and cnt, go to ACCUM.
- ACCUM, on in_valid:
  - sum = acc + sext(in_data) to NACC bits.
  - If cnt == len_q-1 (final sample): dump sum, set acc=0, cnt=0, stay in ACCUM. Consecutive symbols are back-to-back.
  - Otherwise: acc=sum, cnt=cnt+1.
- Gaps in in_valid stall the accumulation only. The result is independent of gap pattern.
- Dump:
  - out_data = sum >>> SHIFT (arithmetic, floor toward negative infinity), clipped to [-2^(NOUT-1), 2^(NOUT-1)-1].
  - out_sat=1 if clipped. out_bit is taken from the sign of the unshifted sum.
- start while in ACCUM discards the partial symbol with no out_valid, re-latches sym_len, and restarts the count.
- start together with in_valid (either state) counts that sample as sample 0 of the new symbol. If len_q is 1 it is also dumped.
- start in the same cycle as a final sample takes priority: the old symbol is discarded and no dump occurs.
- sym_len changes outside a start have no effect.
- There is no exit to IDLE except reset.

## Timing
- Dump latency: out_valid is asserted in the cycle after the final sample's in_valid edge. All outputs are registered.
- out_data, out_bit and out_sat hold their last dumped value until the next dump. out_valid is high for exactly 1 cycle per dump.
- Throughput: 1 sample per cycle. With len_q=1 and in_valid held high, out_valid is high every cycle.
- busy rises the cycle after the first start and stays high until reset.
- Reset assertion mid-symbol clears state and outputs immediately, asynchronously. Release is synchronous to clk, and the first start is accepted on the first edge after release.

## Structure
- Shared package demod_pkg holds:
  - the state enum (ST_IDLE, ST_ACCUM);
  - default widths (NX, NACC, NOUT, SYM_LEN_W) shared with the multiplier stage;
  - a localparam check that NACC >= NX+SYM_LEN_W.
- One sub-module, demod_sat_shift: parameterised arithmetic right shift plus signed saturation from NACC to NOUT bits, with a sat flag output. It is purely combinational and is reused by later stages.

## Test plan
Default parameters, SHIFT=0 unless noted.
- Reset: assert rst_n=0 mid-symbol -> outputs immediately 0 and busy=0. After release, in_valid samples alone produce no out_valid.
- Basic dump: start with sym_len=4, then samples 100, 200, -50, 10 on consecutive cycles -> one cycle after the 4th sample, out_valid=1, out_data=260, out_bit=1, out_sat=0.
- Saturation:
  - Four samples of 32767 -> sum 131068, so out_data=32767, out_sat=1, out_bit=1.
  - Four samples of -32768 -> out_data=-32768, out_sat=1, out_bit=0.
  - With SHIFT=2, four samples of 32767 -> out_data=32767, out_sat=0.
- Gapped and back-to-back:
  - Same 4 samples with random in_valid gaps -> identical result.
  - 12 continuous samples -> exactly 3 out_valid pulses, spaced 4 cycles apart.
  - sym_len=0 -> out_valid every cycle, out_data equal to each sample.
- Realign: start, 2 samples (5, 7), then start together with sample 1 followed by samples 1, 1, 1 -> no dump of 12; single dump with out_data=4.
- Priority: start coincident with the 4th sample of a symbol -> no out_valid that symbol. The coincident sample begins the new symbol.
